// File: rtl/servo_sequencer.sv
// ============================================================================
//  Module      : servo_sequencer
//  Description : Frame-synchronous multi-channel servo pulse scheduler with
//                per-channel target/slew ramping, on the CPU memory bus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module servo_sequencer #(
  parameter int BASETIME = 256,
  parameter int CHANNELS = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic [CHANNELS-1:0] pwm,
  output logic                frame_tick,
  input  logic [31:0]         address_in,
  input  logic                sel_in,
  input  logic                read_in,
  output logic [31:0]         read_value_out,
  input  logic [3:0]          write_mask_in,
  input  logic [31:0]         write_value_in,
  output logic                ready_out
);

  localparam int c_STEP  = BASETIME / 256;
  localparam int c_FRAME = 20 * BASETIME;
  localparam int c_QW    = $clog2(c_FRAME);

  logic [c_QW-1:0]     r_q;
  logic                r_enable;
  logic [15:0]         r_frame_cnt;
  logic [7:0]          r_target [CHANNELS];
  logic [7:0]          r_rate   [CHANNELS];
  logic [7:0]          r_cur    [CHANNELS];
  logic [CHANNELS-1:0] r_pwm;

  logic [3:0]          w_index;
  logic                w_boundary;
  logic                w_ctrl_wr;
  logic [7:0]          w_busy;
  logic signed [8:0]   w_diff     [CHANNELS];
  logic [8:0]          w_mag      [CHANNELS];
  logic [7:0]          w_next_cur [CHANNELS];
  logic [c_QW-1:0]     w_thr      [CHANNELS];
  logic                w_unused;

  assign w_index    = address_in[5:2];
  assign w_boundary = r_enable && (r_q == c_QW'(c_FRAME - 1));
  assign w_ctrl_wr  = sel_in && (w_index == 4'd0) && write_mask_in[0];
  assign frame_tick = w_boundary;
  assign ready_out  = sel_in;
  assign pwm        = r_pwm;

  // Address bits above the word index, byte offsets, the read strobe and the
  // upper write lanes carry no state in this block.
  assign w_unused = ^{address_in[31:6], address_in[1:0], read_in,
                      write_mask_in[3:2], write_value_in[31:16]};

  // Frame counter, enable bit and frame count; disabling parks q at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q         <= '0;
      r_enable    <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_ctrl_wr) r_enable <= write_value_in[0];
      if (!r_enable || w_boundary) r_q <= '0;
      else                         r_q <= r_q + 1'b1;
      if (w_boundary) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // Ramp step: 9-bit signed difference so no 8-bit wrap; snap when within rate.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_diff[i] = $signed({1'b0, r_target[i]}) - $signed({1'b0, r_cur[i]});
      w_mag[i]  = w_diff[i][8] ? $unsigned(-w_diff[i]) : $unsigned(w_diff[i]);
      if ((r_rate[i] == 8'd0) || (w_mag[i] <= {1'b0, r_rate[i]}))
        w_next_cur[i] = r_target[i];
      else if (!w_diff[i][8])
        w_next_cur[i] = r_cur[i] + r_rate[i];
      else
        w_next_cur[i] = r_cur[i] - r_rate[i];
    end
  end

  // Channel registers: bus writes per lane, cur moves only at the frame edge
  // (an old target is used if a target write lands on the boundary cycle).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_target[i] <= '0;
        r_rate[i]   <= '0;
        r_cur[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel_in && (w_index == 4'(4 + i))) begin
          if (write_mask_in[0]) r_target[i] <= write_value_in[7:0];
          if (write_mask_in[1]) r_rate[i]   <= write_value_in[15:8];
        end
        if (w_boundary) r_cur[i] <= w_next_cur[i];
      end
    end
  end

  // Pulse width threshold per channel: BASETIME + cur*STEP clocks.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++)
      w_thr[i] = c_QW'(BASETIME) + c_QW'(c_STEP) * c_QW'(r_cur[i]);
  end

  // Registered pulse compare against the shared frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwm <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        r_pwm[i] <= r_enable && (r_q < w_thr[i]);
    end
  end

  // Busy flags for STATUS; slots beyond CHANNELS stay zero.
  always_comb begin
    w_busy = '0;
    for (int i = 0; i < CHANNELS; i++)
      w_busy[i] = (r_cur[i] != r_target[i]);
  end

  // Read mux; zero when not selected or for unmapped words.
  always_comb begin
    read_value_out = '0;
    if (sel_in) begin
      if (w_index == 4'd0)
        read_value_out = {31'd0, r_enable};
      else if (w_index == 4'd1)
        read_value_out = {8'd0, w_busy, r_frame_cnt};
      for (int i = 0; i < CHANNELS; i++)
        if (w_index == 4'(4 + i))
          read_value_out = {8'd0, r_cur[i], r_rate[i], r_target[i]};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_servo_sequencer.sv
// ============================================================================
//  Module      : tb_servo_sequencer
//  Description : Directed self-checking bench for servo_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_servo_sequencer;

  localparam int BT    = 256;
  localparam int CH    = 4;
  localparam int FRAME = 20 * BT;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] pwm;
  logic          frame_tick;
  logic [31:0]   address_in;
  logic          sel_in;
  logic          read_in;
  logic [31:0]   read_value_out;
  logic [3:0]    write_mask_in;
  logic [31:0]   write_value_in;
  logic          ready_out;

  int n_cmp = 0;
  int n_err = 0;

  servo_sequencer #(.BASETIME(BT), .CHANNELS(CH)) dut (
    .clk            (clk),
    .reset          (reset),
    .pwm            (pwm),
    .frame_tick     (frame_tick),
    .address_in     (address_in),
    .sel_in         (sel_in),
    .read_in        (read_in),
    .read_value_out (read_value_out),
    .write_mask_in  (write_mask_in),
    .write_value_in (write_value_in),
    .ready_out      (ready_out)
  );

  always #5 clk = ~clk;

  // Bus write: called at a negedge, write lands on the next posedge, returns at the following negedge.
  task automatic bus_write(input logic [3:0] idx, input logic [3:0] mask, input logic [31:0] data);
    address_in     = {26'd0, idx, 2'b00};
    sel_in         = 1'b1;
    write_mask_in  = mask;
    write_value_in = data;
    @(posedge clk);
    @(negedge clk);
    sel_in         = 1'b0;
    write_mask_in  = 4'd0;
    write_value_in = 32'd0;
  endtask

  // Bus read: combinational, sampled 1 time unit after presenting the address.
  task automatic bus_read(input logic [3:0] idx, output logic [31:0] data);
    address_in = {26'd0, idx, 2'b00};
    sel_in     = 1'b1;
    read_in    = 1'b1;
    #1;
    data       = read_value_out;
    sel_in     = 1'b0;
    read_in    = 1'b0;
  endtask

  // Advance negedge by negedge until frame_tick is seen; bounded.
  task automatic wait_tick(output int cycles);
    cycles = 0;
    forever begin
      @(negedge clk);
      cycles++;
      if (frame_tick) break;
      if (cycles > FRAME + 16) begin
        n_cmp++;
        n_err++;
        $display("FAIL wait_tick timeout: waited %0d cycles, required tick within %0d", cycles, FRAME);
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; sel_in = 1'b0; read_in = 1'b0; address_in = 32'd0;
    write_mask_in = 4'd0; write_value_in = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (pwm !== 4'd0) begin n_err++; $display("FAIL reset_pwm: got %h required 0", pwm); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b required 0", frame_tick); end
    address_in = 32'h4;
    #1;
    n_cmp++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL ready_idle: got %b required 0", ready_out); end
    n_cmp++; if (read_value_out !== 32'd0) begin n_err++; $display("FAIL read_unsel: got %h required 0", read_value_out); end
    sel_in = 1'b1;
    #1;
    n_cmp++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL ready_sel: got %b required 1", ready_out); end
    sel_in = 1'b0;
    bus_read(4'd0, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_ctrl: got %h required 0", d); end
    bus_read(4'd1, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_status: got %h required 0", d); end
    bus_read(4'd4, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_chan0: got %h required 0", d); end
  endtask

  task automatic test_pulse_width();
    logic [31:0] d;
    int c;
    int hi;
    bus_write(4'd4, 4'b0011, 32'd0);
    bus_write(4'd0, 4'b0001, 32'd1);
    wait_tick(c);
    hi = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (pwm[0]) hi++;
    end
    n_cmp++; if (hi !== BT) begin n_err++; $display("FAIL width_min: got %0d cycles required %0d", hi, BT); end
    n_cmp++; if (frame_tick !== 1'b1) begin n_err++; $display("FAIL tick_period: got %b required 1 after %0d cycles", frame_tick, FRAME); end
    // Target write on the boundary cycle: this boundary still uses target 0.
    bus_write(4'd4, 4'b0001, 32'd255);
    bus_read(4'd4, d);
    n_cmp++; if (d !== 32'h0000_00FF) begin n_err++; $display("FAIL boundary_write: got %h required 000000ff", d); end
    wait_tick(c);
    hi = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (pwm[0]) hi++;
    end
    n_cmp++; if (hi !== BT + 255) begin n_err++; $display("FAIL width_max: got %0d cycles required %0d", hi, BT + 255); end
    bus_read(4'd4, d);
    n_cmp++; if (d !== 32'h00FF_00FF) begin n_err++; $display("FAIL cur_after: got %h required 00ff00ff", d); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    repeat (20) @(negedge clk);
    n_cmp++; if (pwm[0] !== 1'b1) begin n_err++; $display("FAIL midframe_pwm: got %b required 1", pwm[0]); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (pwm !== 4'd0) begin n_err++; $display("FAIL reset_mid_pwm: got %h required 0", pwm); end
    bus_read(4'd0, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_mid_ctrl: got %h required 0", d); end
    bus_read(4'd4, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_mid_chan0: got %h required 0", d); end
    bus_read(4'd1, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_mid_status: got %h required 0", d); end
  endtask

  task automatic test_ramp();
    logic [31:0] d;
    logic [7:0] exp_cur [4];
    int c;
    exp_cur[0] = 8'd30; exp_cur[1] = 8'd60; exp_cur[2] = 8'd90; exp_cur[3] = 8'd100;
    bus_write(4'd5, 4'b0011, {16'd0, 8'd30, 8'd100});
    bus_write(4'd0, 4'b0001, 32'd1);
    for (int k = 0; k < 4; k++) begin
      wait_tick(c);
      n_cmp++; if (c !== FRAME - 1) begin n_err++; $display("FAIL ramp_tick_gap%0d: got %0d required %0d", k, c, FRAME - 1); end
      @(negedge clk);
      bus_read(4'd5, d);
      n_cmp++; if (d !== {8'd0, exp_cur[k], 8'd30, 8'd100}) begin
        n_err++; $display("FAIL ramp_cur%0d: got %h required %h", k, d, {8'd0, exp_cur[k], 8'd30, 8'd100});
      end
      bus_read(4'd1, d);
      n_cmp++; if (d !== ({14'd0, (k < 3), 1'b0, 16'(k + 1)})) begin
        n_err++; $display("FAIL ramp_status%0d: got %h required %h", k, d, {14'd0, (k < 3), 1'b0, 16'(k + 1)});
      end
    end
    bus_write(4'd5, 4'b0001, 32'd95);
    wait_tick(c);
    @(negedge clk);
    bus_read(4'd5, d);
    n_cmp++; if (d !== 32'h005F_1E5F) begin n_err++; $display("FAIL ramp_down: got %h required 005f1e5f", d); end
    bus_write(4'd5, 4'b0010, 32'h0000_0500);
    bus_read(4'd5, d);
    n_cmp++; if (d !== 32'h005F_055F) begin n_err++; $display("FAIL lane1_write: got %h required 005f055f", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    bus_write(4'd15, 4'b1111, 32'hFFFF_FFFF);
    bus_write(4'd8, 4'b1111, 32'hFFFF_FFFF);
    bus_read(4'd15, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL unmapped15: got %h required 0", d); end
    bus_read(4'd8, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL chan_oob: got %h required 0", d); end
    bus_read(4'd0, d);
    n_cmp++; if (d !== 32'd1) begin n_err++; $display("FAIL ctrl_kept: got %h required 1", d); end
    bus_read(4'd5, d);
    n_cmp++; if (d !== 32'h005F_055F) begin n_err++; $display("FAIL chan1_kept: got %h required 005f055f", d); end
    bus_read(4'd4, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL chan0_kept: got %h required 0", d); end
  endtask

  task automatic test_disable();
    logic [31:0] d;
    int c;
    int ticks;
    int hi;
    wait_tick(c);
    repeat (10) @(negedge clk);
    n_cmp++; if (pwm[0] !== 1'b1) begin n_err++; $display("FAIL dis_pre_pwm: got %b required 1", pwm[0]); end
    bus_write(4'd0, 4'b0001, 32'd0);
    @(negedge clk);
    n_cmp++; if (pwm !== 4'd0) begin n_err++; $display("FAIL dis_pwm: got %h required 0", pwm); end
    bus_read(4'd5, d);
    n_cmp++; if (d !== 32'h005F_055F) begin n_err++; $display("FAIL dis_cur: got %h required 005f055f", d); end
    bus_read(4'd1, d);
    n_cmp++; if (d !== 32'd6) begin n_err++; $display("FAIL dis_count: got %h required 6", d); end
    ticks = 0;
    repeat (300) begin
      @(negedge clk);
      if (frame_tick || pwm !== 4'd0) ticks++;
    end
    n_cmp++; if (ticks !== 0) begin n_err++; $display("FAIL dis_idle: got %0d active cycles required 0", ticks); end
    bus_read(4'd1, d);
    n_cmp++; if (d !== 32'd6) begin n_err++; $display("FAIL dis_count_held: got %h required 6", d); end
    bus_write(4'd0, 4'b0001, 32'd1);
    n_cmp++; if (pwm[0] !== 1'b0) begin n_err++; $display("FAIL reen_early: got %b required 0", pwm[0]); end
    @(negedge clk);
    n_cmp++; if (pwm[0] !== 1'b1) begin n_err++; $display("FAIL reen_rise: got %b required 1", pwm[0]); end
    hi = 1;
    for (int k = 0; k < 2 * BT; k++) begin
      @(negedge clk);
      if (!pwm[0]) break;
      hi++;
    end
    n_cmp++; if (hi !== BT) begin n_err++; $display("FAIL reen_width: got %0d required %0d", hi, BT); end
  endtask

  initial begin
    test_reset();
    test_pulse_width();
    test_reset_midframe();
    test_ramp();
    test_unmapped();
    test_disable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
